lz4_src_arbiter: RTL and testbench

Frame-level arbiter that shares the single compressed-byte input of the LZ4 decoder among three byte-stream sources: the Wishbone slave, the UART receiver and the logic-analyser port. It grants one source for a whole compressed frame, ending on that source's last byte, then rotates round-robin. It drives the decoder through one registered valid/ready stage. It sits between the source adapters and the decoder inside the decoder top level.

---
 rtl/lz4_arb_pkg.sv | 19 +
 rtl/lz4_rr_pick.sv | 29 ++
 rtl/lz4_src_arbiter.sv | 143 ++++++++++++++
 tb/tb_lz4_src_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz4_arb_pkg.sv
// Shared source indices, FSM encoding and pointer helper for the LZ4 source arbiter.
package lz4_arb_pkg;

   localparam int unsigned SRC_WB   = 0;
   localparam int unsigned SRC_UART = 1;
   localparam int unsigned SRC_LA   = 2;
   localparam int unsigned N_SRC    = 3;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Next round-robin start position: one past idx, wrapping LA back to WB.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'(SRC_LA)) ? 2'(SRC_WB) : idx + 2'd1;
   endfunction

endpackage

// File: rtl/lz4_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping LA to WB.
module lz4_rr_pick
   import lz4_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] sel;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sel = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         sel = 2'((32'(ptr) + k) % N_SRC);
         if (!any && req[sel]) begin
            any      = 1'b1;
            gnt[sel] = 1'b1;
            idx      = sel;
         end
      end
   end

endmodule

// File: rtl/lz4_src_arbiter.sv
// Frame-level round-robin arbiter feeding the LZ4 decoder through one registered stage.
// Optional mid-frame idle timeout is built only when LZ4_ARB_TIMEOUT_EN is defined.
module lz4_src_arbiter
   import lz4_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [2:0]  req_valid,
   input  logic [23:0] req_data,
   input  logic [2:0]  req_last,
   output logic [2:0]  req_ready,
   output logic        dec_valid,
   output logic [7:0]  dec_data,
   output logic        dec_last,
   input  logic        dec_ready,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        abort
);

   arb_state_t       state_q, state_d;
   logic [2:0]       grant_d;
   logic [1:0]       gidx_q, gidx_d;
   logic [1:0]       rr_q, rr_d;
   logic             abort_d;
   logic [2:0]       pick_gnt;
   logic [1:0]       pick_idx;
   logic             pick_any;
   logic             out_free, xfer, last_g, idle_g, timeout;
   logic [7:0]       data_g;
   logic [TMR_W-1:0] timer;

   lz4_rr_pick u_pick (
      .req (req_valid),
      .ptr (rr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign out_free  = ~dec_valid | dec_ready;
   assign req_ready = grant & {N_SRC{out_free}};
   assign xfer      = |(req_valid & req_ready);
   assign last_g    = |(req_last & grant);
   assign idle_g    = (state_q == LOCK) & ~|(req_valid & grant);

   always_comb begin
      case (gidx_q)
         2'(SRC_UART): data_g = req_data[15:8];
         2'(SRC_LA):   data_g = req_data[23:16];
         default:      data_g = req_data[7:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && pick_any) begin
               state_d = LOCK;
               grant_d = pick_gnt;
               gidx_d  = pick_idx;
            end
         end
         LOCK: begin
            if (xfer && last_g) begin
               state_d = IDLE;
               grant_d = '0;
               rr_d    = rr_next(gidx_q);
            end else if (timeout) begin
               state_d = IDLE;
               grant_d = '0;
               rr_d    = rr_next(gidx_q);
               abort_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant   <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         busy    <= 1'b0;
         abort   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         busy    <= (state_d == LOCK);
         abort   <= abort_d;
      end
   end

   // Output stage ignores the grant so a byte pending at frame end or abort still drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_valid <= 1'b0;
         dec_data  <= '0;
         dec_last  <= 1'b0;
      end else if (xfer) begin
         dec_valid <= 1'b1;
         dec_data  <= data_g;
         dec_last  <= last_g;
      end else if (dec_ready) begin
         dec_valid <= 1'b0;
      end
   end

`ifdef LZ4_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (state_q != LOCK || xfer || timeout) begin
         timer <= '0;
      end else if (idle_g) begin
         timer <= timer + TMR_W'(1);
      end
   end
`else
   localparam bit TMO_EN = 1'b0;

   assign timer = '0;
`endif

   // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES.
   assign timeout = TMO_EN & idle_g & (timer == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: tb/tb_lz4_src_arbiter.sv
// Self-checking bench for lz4_src_arbiter: grant vector table, directed corner
// sequences and randomized multi-source traffic against a frame-level scoreboard.
`timescale 1ns/1ps
module tb_lz4_src_arbiter;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_data = '0;
   logic [2:0]  req_last = '0;
   logic [2:0]  req_ready;
   logic        dec_valid;
   logic [7:0]  dec_data;
   logic        dec_last;
   logic        dec_ready = 1'b0;
   logic [2:0]  grant;
   logic        busy;
   logic        abort;

   always #5 clk = ~clk;

   lz4_src_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .dec_valid (dec_valid),
      .dec_data  (dec_data),
      .dec_last  (dec_last),
      .dec_ready (dec_ready),
      .grant     (grant),
      .busy      (busy),
      .abort     (abort)
   );

   int n_pass = 0;
   int n_total = 0;
   int prot_err = 0;
   int cyc = 0;

   logic [8:0] src_q [3][$];
   logic [8:0] exp_q [3][$];
   int         frame_src[$];
   int         frame_start[$];
   int         frame_end[$];
   bit         open_f[3];

   typedef struct {
      logic [2:0] v1;
      logic [2:0] g1;
      logic [7:0] d1;
      logic [2:0] v2;
      logic [2:0] g2;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      dec_ready = 1'b0;
      enable    = 1'b0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
         open_f[i] = 1'b0;
      end
      frame_src.delete();
      frame_start.delete();
      frame_end.delete();
   endtask

   task automatic gen_frames(input int s, input int nf, input int lmin, input int lmax);
      int         len;
      logic [5:0] seq;
      logic [8:0] ent;
      seq = 6'($urandom);
      for (int f = 0; f < nf; f++) begin
         len = int'($urandom_range(lmax, lmin));
         for (int b = 0; b < len; b++) begin
            ent = {(b == len - 1), 2'(s), seq};
            src_q[s].push_back(ent);
            exp_q[s].push_back(ent);
            seq++;
         end
      end
   endtask

   // Sources present queued bytes with random gaps (never more than 3 idle cycles
   // while data is pending); the scoreboard checks per-source order, last flags and
   // that frames never interleave on the decoder side.
   task automatic traffic(input int gap_pct, input int bp_pct);
      int         off_cnt[3];
      int         budget;
      logic [2:0] acc;
      logic       dh;
      logic [7:0] dd;
      logic       dl;
      logic [8:0] ent;
      bit         in_frame;
      int         cur;
      int         s;
      off_cnt  = '{0, 0, 0};
      budget   = 3000;
      in_frame = 1'b0;
      cur      = 0;
      while (budget > 0 && (src_q[0].size() + src_q[1].size() + src_q[2].size() +
                            exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0) begin
         budget--;
         for (int i = 0; i < 3; i++) begin
            if (src_q[i].size() > 0 && (int'($urandom_range(99)) >= gap_pct || off_cnt[i] >= 3)) begin
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = src_q[i][0][7:0];
               req_last[i]        = src_q[i][0][8];
               off_cnt[i]         = 0;
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
               if (src_q[i].size() > 0) off_cnt[i]++;
            end
         end
         dec_ready = (int'($urandom_range(99)) >= bp_pct);
         #1;
         acc = req_valid & req_ready;
         dh  = dec_valid & dec_ready;
         dd  = dec_data;
         dl  = dec_last;
         if (!$onehot0(grant) || (req_ready & ~grant) != 3'b000 || busy != (grant != 3'b000))
            prot_err++;
         step();
         for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
               ent = src_q[i].pop_front();
               if (!open_f[i]) begin
                  frame_src.push_back(i);
                  frame_start.push_back(cyc);
                  open_f[i] = 1'b1;
               end
               if (ent[8]) begin
                  open_f[i] = 1'b0;
                  frame_end.push_back(cyc);
               end
            end
         end
         if (dh) begin
            s = int'(dd[7:6]);
            if (s > 2 || exp_q[s].size() == 0) begin
               prot_err++;
               $display("FAIL sb_src: byte 0x%0h has no pending source", dd);
            end else begin
               ent = exp_q[s].pop_front();
               chk("sb_byte", int'({dl, dd}), int'(ent));
               if (in_frame && s != cur) prot_err++;
               in_frame = !dl;
               cur      = s;
            end
         end
      end
      req_valid = '0;
      req_last  = '0;
      chk("traffic_drained", int'(budget > 0), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      logic [7:0] ub[4];
      int         rr_bad, held_bad, n_ab, first_ab, g_seen;

      tbl[0] = '{3'b001, 3'b001, 8'hA0, 3'b111, 3'b010};
      tbl[1] = '{3'b100, 3'b100, 8'hA2, 3'b011, 3'b001};
      tbl[2] = '{3'b110, 3'b010, 8'hA1, 3'b011, 3'b001};
      tbl[3] = '{3'b010, 3'b010, 8'hA1, 3'b110, 3'b100};
      tbl[4] = '{3'b101, 3'b001, 8'hA0, 3'b101, 3'b100};
      tbl[5] = '{3'b011, 3'b001, 8'hA0, 3'b010, 3'b010};

      // Reset state
      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_dec_data", dec_data, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_abort", abort, 0);

      // Grant decision table: first decision from rr_ptr=0, second after one frame
      for (int k = 0; k < 6; k++) begin
         do_reset();
         enable    = 1'b1;
         dec_ready = 1'b1;
         req_data  = 24'hA2A1A0;
         req_last  = 3'b111;
         req_valid = tbl[k].v1;
         step();
         chk($sformatf("tbl%0d_grant1", k), grant, tbl[k].g1);
         chk($sformatf("tbl%0d_no_xfer", k), dec_valid, 0);
         step();
         chk($sformatf("tbl%0d_data", k), dec_data, tbl[k].d1);
         chk($sformatf("tbl%0d_released", k), grant, 0);
         req_valid = tbl[k].v2;
         step();
         chk($sformatf("tbl%0d_grant2", k), grant, tbl[k].g2);
      end

      // UART-only 4-byte frame
      do_reset();
      ub[0] = 8'h11; ub[1] = 8'h22; ub[2] = 8'h33; ub[3] = 8'h44;
      enable = 1'b1;
      dec_ready = 1'b1;
      req_valid = 3'b010;
      req_data[15:8] = ub[0];
      step();
      chk("uart_grant", grant, 3'b010);
      chk("uart_bubble", dec_valid, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("uart_byte%0d", k), int'({dec_valid, dec_last, dec_data}),
             int'({1'b1, (k == 3), ub[k]}));
         if (k < 3) begin
            req_data[15:8] = ub[k+1];
            req_last[1]    = (k + 1 == 3);
         end
      end
      chk("uart_grant_clear", grant, 0);
      req_valid = '0;
      req_last  = '0;
      step();
      chk("uart_drained", dec_valid, 0);

      // All sources continuously requesting 2-byte frames
      do_reset();
      enable = 1'b1;
      for (int s = 0; s < 3; s++) gen_frames(s, 2, 2, 2);
      traffic(0, 0);
      chk("rr_frames", frame_src.size(), 6);
      for (int k = 0; k < frame_src.size(); k++)
         chk($sformatf("rr_order%0d", k), frame_src[k], k % 3);
      for (int k = 0; k + 1 < frame_start.size() && k < frame_end.size(); k++)
         chk($sformatf("rr_gap%0d", k), frame_start[k+1] - frame_end[k], 2);

      // Decoder backpressure mid-frame
      do_reset();
      enable = 1'b1;
      dec_ready = 1'b1;
      req_valid = 3'b001;
      req_data[7:0] = 8'h51;
      step();
      chk("bp_grant", grant, 3'b001);
      step();
      chk("bp_first", dec_data, 8'h51);
      req_data[7:0] = 8'h52;
      dec_ready = 1'b0;
      rr_bad = 0; held_bad = 0; n_ab = 0;
      repeat (10) begin
         #1;
         if (req_ready[0]) rr_bad++;
         step();
         if (dec_data != 8'h51 || !dec_valid) held_bad++;
         if (abort) n_ab++;
      end
      chk("bp_ready_low", rr_bad, 0);
      chk("bp_held", held_bad, 0);
      chk("bp_no_abort", n_ab, 0);
      dec_ready = 1'b1;
      step();
      chk("bp_second", int'({dec_valid, dec_data}), int'({1'b1, 8'h52}));
      req_data[7:0] = 8'h53;
      req_last[0] = 1'b1;
      step();
      chk("bp_third", int'({dec_last, dec_data}), int'({1'b1, 8'h53}));
      req_valid = '0;
      req_last = '0;
      step();
      chk("bp_no_dup", dec_valid, 0);

`ifdef LZ4_ARB_TIMEOUT_EN
      // Granted WB stalls after one byte while LA waits
      do_reset();
      enable = 1'b1;
      dec_ready = 1'b1;
      req_valid = 3'b101;
      req_data = {8'h71, 8'h00, 8'h61};
      req_last = 3'b100;
      step();
      chk("to_grant", grant, 3'b001);
      step();
      chk("to_first", dec_data, 8'h61);
      req_valid = 3'b100;
      dec_ready = 1'b0;
      n_ab = 0; first_ab = -1;
      for (int k = 1; k <= int'(TO) + 4; k++) begin
         step();
         if (abort) begin
            n_ab++;
            if (first_ab < 0) first_ab = k;
         end
      end
      chk("to_abort_count", n_ab, 1);
      chk("to_abort_cycle", first_ab, TO);
      chk("to_pending_kept", int'({dec_valid, dec_data}), int'({1'b1, 8'h61}));
      chk("to_next_grant", grant, 3'b100);
      dec_ready = 1'b1;
      step();
      chk("to_la_byte", int'({dec_last, dec_data}), int'({1'b1, 8'h71}));
      req_valid = '0;
      req_last = '0;
`endif

      // Asynchronous reset mid-frame from LA
      do_reset();
      enable = 1'b1;
      req_valid = 3'b100;
      req_data[23:16] = 8'h7A;
      step();
      step();
      chk("mid_pre_data", int'({dec_valid, dec_data}), int'({1'b1, 8'h7A}));
      dec_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out", int'({dec_valid, dec_last, dec_data}), 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_abort", abort, 0);
      step();
      rst = 1'b0;
      req_valid = 3'b101;
      req_data = {8'h7B, 8'h00, 8'h01};
      step();
      chk("mid_regrant_wb", grant, 3'b001);

      // enable dropped during a WB frame with UART waiting
      do_reset();
      enable = 1'b1;
      dec_ready = 1'b1;
      req_valid = 3'b011;
      req_data = {8'h00, 8'h91, 8'h81};
      req_last = 3'b010;
      step();
      chk("en_grant_wb", grant, 3'b001);
      enable = 1'b0;
      step();
      chk("en_byte0", dec_data, 8'h81);
      req_data[7:0] = 8'h82;
      req_last[0] = 1'b1;
      step();
      chk("en_byte1", int'({dec_last, dec_data}), int'({1'b1, 8'h82}));
      req_valid = 3'b010;
      req_last[0] = 1'b0;
      g_seen = 0;
      repeat (4) begin
         step();
         if (grant != 3'b000 || busy) g_seen++;
      end
      chk("en_no_grant", g_seen, 0);
      enable = 1'b1;
      step();
      chk("en_grant_uart", grant, 3'b010);

      // Randomized traffic with gaps and backpressure
      do_reset();
      enable = 1'b1;
      for (int s = 0; s < 3; s++) gen_frames(s, 5, 1, 6);
      traffic(30, 30);
      chk("rand_frames", frame_src.size(), 15);
      chk("protocol", prot_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
